// File: rtl/vga_pkg.sv
// Shared raster timing types and default 640x480@60 Hz timing constants.
package vga_pkg;

  typedef enum logic [1:0] {ACTIVE, FRONT, SYNC, BACK} vga_axis_state_t;

  localparam int CNT_W = 10;

  localparam int HVID  = 640;
  localparam int HFP   = 16;
  localparam int HSYNC = 96;
  localparam int HBP   = 48;
  localparam int HTOT  = HVID + HFP + HSYNC + HBP;

  localparam int VVID  = 480;
  localparam int VFP   = 10;
  localparam int VSYNC = 2;
  localparam int VBP   = 33;
  localparam int VTOT  = VVID + VFP + VSYNC + VBP;

endpackage

// File: rtl/vga_timing_gen_if.sv
// Raster timing bundle from the timing generator to the pattern stage and connector.
interface vga_timing_gen_if;
  import vga_pkg::*;

  logic [CNT_W-1:0] horizontal_num;
  logic [CNT_W-1:0] vertical_num;
  logic             load_enable;
  logic             hsync;
  logic             vsync;
  logic             line_start;
  logic             frame_start;

  modport master (
    output horizontal_num, vertical_num, load_enable,
    output hsync, vsync, line_start, frame_start
  );

  modport slave (
    input horizontal_num, vertical_num, load_enable,
    input hsync, vsync, line_start, frame_start
  );

endinterface

// File: rtl/vga_axis_counter.sv
// One raster axis: position counter plus ACTIVE/FRONT/SYNC/BACK region FSM.
// The state always describes the current count, so region changes land on the count edge.
module vga_axis_counter
  import vga_pkg::*;
#(
  parameter int VID  = vga_pkg::HVID,
  parameter int FP   = vga_pkg::HFP,
  parameter int SYNC = vga_pkg::HSYNC,
  parameter int BP   = vga_pkg::HBP
) (
  input  logic             clk_25,
  input  logic             TD_RESET,
  input  logic             adv,
  output logic [CNT_W-1:0] cnt,
  output vga_axis_state_t  state,
  output logic             wrap
);

  localparam int TOT = VID + FP + SYNC + BP;

  localparam logic [CNT_W-1:0] END_VID  = CNT_W'(VID - 1);
  localparam logic [CNT_W-1:0] END_FP   = CNT_W'(VID + FP - 1);
  localparam logic [CNT_W-1:0] END_SYNC = CNT_W'(VID + FP + SYNC - 1);
  localparam logic [CNT_W-1:0] END_TOT  = CNT_W'(TOT - 1);

  if (TOT > (1 << CNT_W) || VID < 1 || FP < 1 || SYNC < 1 || BP < 1) begin : g_bad_timing
    $error("vga_axis_counter: illegal timing VID=%0d FP=%0d SYNC=%0d BP=%0d", VID, FP, SYNC, BP);
  end

  logic [CNT_W-1:0] cnt_q, cnt_d;
  vga_axis_state_t  state_q, state_d;

  always_comb begin
    wrap    = adv && (cnt_q == END_TOT);
    cnt_d   = cnt_q;
    state_d = state_q;
    if (adv) begin
      cnt_d = wrap ? '0 : cnt_q + 1'b1;
      case (state_q)
        vga_pkg::ACTIVE: if (cnt_q == END_VID)  state_d = vga_pkg::FRONT;
        vga_pkg::FRONT:  if (cnt_q == END_FP)   state_d = vga_pkg::SYNC;
        vga_pkg::SYNC:   if (cnt_q == END_SYNC) state_d = vga_pkg::BACK;
        vga_pkg::BACK:   if (wrap)              state_d = vga_pkg::ACTIVE;
        default:                                state_d = vga_pkg::ACTIVE;
      endcase
    end
  end

  always_ff @(posedge clk_25) begin
    if (TD_RESET) begin
      cnt_q   <= '0;
      state_q <= vga_pkg::ACTIVE;
    end else begin
      cnt_q   <= cnt_d;
      state_q <= state_d;
    end
  end

  assign cnt   = cnt_q;
  assign state = state_q;

endmodule

// File: rtl/vga_timing_gen.sv
// 640x480@60 Hz raster timing generator: H/V axis counters feeding one rank of
// output registers, so every output lags the counters by exactly one clock.
module vga_timing_gen
  import vga_pkg::*;
#(
  parameter int HVID     = vga_pkg::HVID,
  parameter int HFP      = vga_pkg::HFP,
  parameter int HSYNC    = vga_pkg::HSYNC,
  parameter int HBP      = vga_pkg::HBP,
  parameter int VVID     = vga_pkg::VVID,
  parameter int VFP      = vga_pkg::VFP,
  parameter int VSYNC    = vga_pkg::VSYNC,
  parameter int VBP      = vga_pkg::VBP,
  parameter bit SYNC_POL = 1'b0
) (
  input  logic              clk_25,
  input  logic              TD_RESET,
  vga_timing_gen_if.master  vga
);

  logic [CNT_W-1:0] h_cnt, v_cnt;
  vga_axis_state_t  h_state, v_state;
  logic             h_wrap, v_wrap;

  vga_axis_counter #(.VID(HVID), .FP(HFP), .SYNC(HSYNC), .BP(HBP)) u_h_axis (
    .clk_25   (clk_25),
    .TD_RESET (TD_RESET),
    .adv      (1'b1),
    .cnt      (h_cnt),
    .state    (h_state),
    .wrap     (h_wrap)
  );

  vga_axis_counter #(.VID(VVID), .FP(VFP), .SYNC(VSYNC), .BP(VBP)) u_v_axis (
    .clk_25   (clk_25),
    .TD_RESET (TD_RESET),
    .adv      (h_wrap),
    .cnt      (v_cnt),
    .state    (v_state),
    .wrap     (v_wrap)
  );

  // The frame can only end on the last pixel of a line.
  a_v_wrap_on_h_wrap: assert property (@(posedge clk_25) disable iff (TD_RESET) v_wrap |-> h_wrap);

  logic [CNT_W-1:0] h_num_q, h_num_d;
  logic [CNT_W-1:0] v_num_q, v_num_d;
  logic             load_en_q, load_en_d;
  logic             hsync_q, hsync_d;
  logic             vsync_q, vsync_d;
  logic             line_start_q, line_start_d;
  logic             frame_start_q, frame_start_d;

  always_comb begin
    h_num_d       = h_cnt;
    v_num_d       = v_cnt;
    load_en_d     = (h_state == ACTIVE) && (v_state == ACTIVE);
    hsync_d       = (h_state == SYNC) ? SYNC_POL : ~SYNC_POL;
    vsync_d       = (v_state == SYNC) ? SYNC_POL : ~SYNC_POL;
    line_start_d  = (h_cnt == '0);
    frame_start_d = (h_cnt == '0) && (v_cnt == '0);
  end

  // Output register stage: reset forces syncs inactive at once, never stretching a pulse.
  always_ff @(posedge clk_25) begin
    if (TD_RESET) begin
      h_num_q       <= '0;
      v_num_q       <= '0;
      load_en_q     <= 1'b0;
      hsync_q       <= ~SYNC_POL;
      vsync_q       <= ~SYNC_POL;
      line_start_q  <= 1'b0;
      frame_start_q <= 1'b0;
    end else begin
      h_num_q       <= h_num_d;
      v_num_q       <= v_num_d;
      load_en_q     <= load_en_d;
      hsync_q       <= hsync_d;
      vsync_q       <= vsync_d;
      line_start_q  <= line_start_d;
      frame_start_q <= frame_start_d;
    end
  end

  assign vga.horizontal_num = h_num_q;
  assign vga.vertical_num   = v_num_q;
  assign vga.load_enable    = load_en_q;
  assign vga.hsync          = hsync_q;
  assign vga.vsync          = vsync_q;
  assign vga.line_start     = line_start_q;
  assign vga.frame_start    = frame_start_q;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen: standard 640x480 instance plus a tiny 16x7 instance,
// both checked every cycle against an arithmetic raster model, with random resets.
module tb_vga_timing_gen;

  typedef struct packed {
    logic [9:0] h;
    logic [9:0] v;
    logic       le;
    logic       hs;
    logic       vs;
    logic       ls;
    logic       fs;
  } obs_t;

  logic clk = 1'b0;
  logic rst_s = 1'b1;
  logic rst_m = 1'b1;

  int n_chk  = 0;
  int n_fail = 0;

  always #20 clk = ~clk;

  vga_timing_gen_if ifs ();
  vga_timing_gen_if ifm ();

  vga_timing_gen dut_std (
    .clk_25   (clk),
    .TD_RESET (rst_s),
    .vga      (ifs)
  );

  vga_timing_gen #(
    .HVID(8), .HFP(2), .HSYNC(3), .HBP(3),
    .VVID(4), .VFP(1), .VSYNC(1), .VBP(1), .SYNC_POL(1'b0)
  ) dut_small (
    .clk_25   (clk),
    .TD_RESET (rst_m),
    .vga      (ifm)
  );

  // Expected outputs from raster arithmetic: pos = cycles since reset release.
  function automatic obs_t model(input int hv, input int hf, input int hsw, input int hb,
                                 input int vv, input int vf, input int vsw, input int vb,
                                 input bit in_rst, input longint pos);
    obs_t   o;
    longint ht, vt, h, v;
    ht = hv + hf + hsw + hb;
    vt = vv + vf + vsw + vb;
    if (in_rst) begin
      o = '{h: 10'd0, v: 10'd0, le: 1'b0, hs: 1'b1, vs: 1'b1, ls: 1'b0, fs: 1'b0};
    end else begin
      h    = pos % ht;
      v    = (pos / ht) % vt;
      o.h  = 10'(h);
      o.v  = 10'(v);
      o.le = (h < hv) && (v < vv);
      o.hs = !((h >= hv + hf) && (h < hv + hf + hsw));
      o.vs = !((v >= vv + vf) && (v < vv + vf + vsw));
      o.ls = (h == 0);
      o.fs = (h == 0) && (v == 0);
    end
    return o;
  endfunction

  task automatic chk(input string name, input longint act, input longint exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic chk_obs(input string name, input obs_t act, input obs_t exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got h=%0d v=%0d le=%b hs=%b vs=%b ls=%b fs=%b, expected h=%0d v=%0d le=%b hs=%b vs=%b ls=%b fs=%b (t=%0t)",
               name, act.h, act.v, act.le, act.hs, act.vs, act.ls, act.fs,
               exp.h, exp.v, exp.le, exp.hs, exp.vs, exp.ls, exp.fs, $time);
    end
  endtask

  function automatic obs_t get_std();
    return {ifs.horizontal_num, ifs.vertical_num, ifs.load_enable, ifs.hsync,
            ifs.vsync, ifs.line_start, ifs.frame_start};
  endfunction

  function automatic obs_t get_small();
    return {ifm.horizontal_num, ifm.vertical_num, ifm.load_enable, ifm.hsync,
            ifm.vsync, ifm.line_start, ifm.frame_start};
  endfunction

  // Reference bookkeeping: cycle counts since the last reset edge.
  bit     s_valid = 1'b0, m_valid = 1'b0;
  bit     s_rst = 1'b1, m_rst = 1'b1;
  longint s_k = 0, m_k = 0, s_pos = 0, m_pos = 0;

  always @(posedge clk) begin
    s_valid <= 1'b1;
    if (rst_s) begin
      s_rst <= 1'b1;
      s_k   <= 0;
    end else begin
      s_rst <= 1'b0;
      s_pos <= s_k;
      s_k   <= s_k + 1;
    end
    m_valid <= 1'b1;
    if (rst_m) begin
      m_rst <= 1'b1;
      m_k   <= 0;
    end else begin
      m_rst <= 1'b0;
      m_pos <= m_k;
      m_k   <= m_k + 1;
    end
  end

  always @(negedge clk) begin
    if (s_valid)
      chk_obs("std_model", get_std(), model(640, 16, 96, 48, 480, 10, 2, 33, s_rst, s_pos));
    if (m_valid)
      chk_obs("small_model", get_small(), model(8, 2, 3, 3, 4, 1, 1, 1, m_rst, m_pos));
  end

  initial begin
    obs_t o;
    int   s_ls_prev, s_le, s_hs, s_hs_first;
    int   m_fs_prev, m_le, m_hs, m_vs, m_bad;
    int   prev_h, prev_v, mprev_h, mprev_v;
    bit   found;

    // Reset held for five cycles.
    repeat (5) @(negedge clk);
    chk_obs("std_reset_vals", get_std(),
            '{h: 10'd0, v: 10'd0, le: 1'b0, hs: 1'b1, vs: 1'b1, ls: 1'b0, fs: 1'b0});
    chk_obs("small_reset_vals", get_small(),
            '{h: 10'd0, v: 10'd0, le: 1'b0, hs: 1'b1, vs: 1'b1, ls: 1'b0, fs: 1'b0});
    rst_s = 1'b0;
    rst_m = 1'b0;

    // First line on std plus many frames of the small instance.
    s_ls_prev = -1; s_le = 0; s_hs = 0; s_hs_first = -1;
    m_fs_prev = -1; m_le = 0; m_hs = 0; m_vs = 0; m_bad = 0;
    prev_h = -1; prev_v = -1; mprev_h = -1; mprev_v = -1;
    for (int t = 0; t < 1700; t++) begin
      @(negedge clk);
      if (t == 0) begin
        chk_obs("std_first_out", get_std(),
                '{h: 10'd0, v: 10'd0, le: 1'b1, hs: 1'b1, vs: 1'b1, ls: 1'b1, fs: 1'b1});
        chk_obs("small_first_out", get_small(),
                '{h: 10'd0, v: 10'd0, le: 1'b1, hs: 1'b1, vs: 1'b1, ls: 1'b1, fs: 1'b1});
      end
      o = get_std();
      if (o.ls) begin
        if (s_ls_prev >= 0) chk("std_line_period", t - s_ls_prev, 800);
        s_ls_prev = t;
      end
      if (o.v == 10'd0 && o.le) s_le++;
      if (o.v == 10'd0 && !o.hs) begin
        if (s_hs_first < 0) s_hs_first = int'(o.h);
        s_hs++;
      end
      if (prev_h == 799) chk("std_h_wrap", {o.h, o.v}, {10'd0, 10'(prev_v + 1)});
      prev_h = int'(o.h);
      prev_v = int'(o.v);

      o = get_small();
      if (o.fs) begin
        if (m_fs_prev >= 0) begin
          chk("small_frame_period", t - m_fs_prev, 112);
          chk("small_le_per_frame", m_le, 32);
          chk("small_hs_per_frame", m_hs, 21);
          chk("small_vs_per_frame", m_vs, 16);
          chk("small_out_of_region", m_bad, 0);
        end
        m_fs_prev = t;
        m_le = 0; m_hs = 0; m_vs = 0; m_bad = 0;
      end
      if (o.le) begin
        m_le++;
        if (o.h >= 10'd8 || o.v >= 10'd4) m_bad++;
      end
      if (!o.hs) begin
        m_hs++;
        if (o.h < 10'd10 || o.h > 10'd12) m_bad++;
      end
      if (!o.vs) begin
        m_vs++;
        if (o.v != 10'd5) m_bad++;
      end
      if (mprev_h == 15 && mprev_v == 6)
        chk("small_frame_wrap", {o.h, o.v, o.fs}, {10'd0, 10'd0, 1'b1});
      mprev_h = int'(o.h);
      mprev_v = int'(o.v);
    end
    chk("std_le_line0", s_le, 640);
    chk("std_hs_width", s_hs, 96);
    chk("std_hs_first_h", s_hs_first, 656);

    // Reset in the middle of both sync pulses on the small instance.
    found = 1'b0;
    for (int i = 0; i < 300 && !found; i++) begin
      @(negedge clk);
      if (ifm.horizontal_num == 10'd11 && ifm.vertical_num == 10'd5) found = 1'b1;
    end
    chk("small_sync_reached", found, 1);
    chk("small_in_both_sync", {ifm.hsync, ifm.vsync}, 2'b00);
    rst_m = 1'b1;
    @(negedge clk);
    chk_obs("small_abort_reset", get_small(),
            '{h: 10'd0, v: 10'd0, le: 1'b0, hs: 1'b1, vs: 1'b1, ls: 1'b0, fs: 1'b0});
    rst_m = 1'b0;
    @(negedge clk);
    chk_obs("small_restart", get_small(),
            '{h: 10'd0, v: 10'd0, le: 1'b1, hs: 1'b1, vs: 1'b1, ls: 1'b1, fs: 1'b1});

    // Random run lengths with random reset pulses on either instance.
    for (int i = 0; i < 40; i++) begin
      int r;
      repeat ($urandom_range(1, 400)) @(negedge clk);
      r = int'($urandom_range(0, 3));
      if (r[0]) rst_m = 1'b1;
      if (r[1]) rst_s = 1'b1;
      repeat ($urandom_range(1, 3)) @(negedge clk);
      rst_m = 1'b0;
      rst_s = 1'b0;
    end
    repeat (200) @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
